// File: rtl/mult_share_arb_if.sv
// Requester/multiplier bundle for mult_share_arb. The slave modport is the arbiter
// side and the master modport is the requester/multiplier side.
interface mult_share_arb_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       resp_valid;
  logic [2*WIDTH-1:0]     resp_p;
  logic                   resp_err;
  logic                   busy;
  logic                   mult_start;
  logic [WIDTH-1:0]       mult_a;
  logic [WIDTH-1:0]       mult_b;
  logic [2*WIDTH-1:0]     mult_p;
  logic                   mult_done;

  modport slave (
    input  req_valid, req_a, req_b, mult_p, mult_done,
    output req_ready, resp_valid, resp_p, resp_err, busy, mult_start, mult_a, mult_b
  );

  modport master (
    output req_valid, req_a, req_b, mult_p, mult_done,
    input  req_ready, resp_valid, resp_p, resp_err, busy, mult_start, mult_a, mult_b
  );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier among N_REQ requesters.
// Optional WAIT-state abort is enabled by defining MULT_SHARE_ARB_TIMEOUT_EN.
module mult_share_arb #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  mult_share_arb_if.slave bus
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("mult_share_arb: N_REQ must be 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_tmo
    $error("mult_share_arb: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      last_q, last_d;
  logic [GW-1:0]      gnt_q, gnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] resp_p_q, resp_p_d;
  logic               resp_err_q, resp_err_d;

  logic [GW-1:0]      pick;
  logic               pick_vld;
  logic               tmo_hit;
  logic [N_REQ-1:0]   req_ready_c;
  logic [N_REQ-1:0]   resp_valid_c;
  logic               mult_start_c;

  // Rotating priority: walk offsets from far to near so the nearest valid
  // requester after last_q is the one left standing.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    for (int off = N_REQ; off >= 1; off--) begin
      logic [GW-1:0] ix;
      ix = GW'((int'(last_q) + off) % N_REQ);
      if (bus.req_valid[ix]) begin
        pick     = ix;
        pick_vld = 1'b1;
      end
    end
  end

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Held at zero outside WAIT, so it restarts on every WAIT entry.
  always_comb begin
    tmo_d = '0;
    if (state_q == S_WAIT) tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    resp_p_d     = resp_p_q;
    resp_err_d   = resp_err_q;
    req_ready_c  = '0;
    resp_valid_c = '0;
    mult_start_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld && !rst) begin
          req_ready_c[pick] = 1'b1;
          gnt_d             = pick;
          opa_d             = bus.req_a[int'(pick)*WIDTH +: WIDTH];
          opb_d             = bus.req_b[int'(pick)*WIDTH +: WIDTH];
          state_d           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mult_start_c = !rst;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mult_done) begin
          resp_p_d   = bus.mult_p;
          resp_err_d = 1'b0;
          state_d    = S_RESP;
        end else if (tmo_hit) begin
          resp_p_d   = '0;
          resp_err_d = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid_c[gnt_q] = !rst;
        last_d              = gnt_q;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= GW'(N_REQ - 1);
      gnt_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      resp_p_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      resp_p_q   <= resp_p_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_p     = resp_p_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.mult_start = mult_start_c;
  assign bus.mult_a     = opa_q;
  assign bus.mult_b     = opb_q;

endmodule
